seven_seg_scanner: RTL and testbench

Display back-end fed by the processor top. Takes a 32-bit value from the CPU, double-buffers it, and time-multiplexes eight hex digits onto a common-anode seven-segment bank (out7 / en_out). Updates are applied only at frame boundaries so a digit never shows a mix of old and new data.

---
 rtl/seven_seg_scanner.sv | 142 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: double-buffered eight-digit hex scanner for a
// common-anode seven-segment bank. A 32-bit value is captured on Load into a
// shadow register and promoted to the display register only at the frame
// boundary (index 7 terminal count), so a frame never mixes old and new data.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> digits k>0 whose nibbles k..7 are all zero keep their anode off
//   undefined -> all eight digits are always lit in turn
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] DataIn,
    input  logic        Load,
    input  logic        Blank,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic        FrameTick
);

    localparam int             PW       = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRESC_TC = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [31:0]   r_shadow;
    logic [31:0]   r_display;
    logic          r_pending;

    logic          w_tc;
    logic          w_wrap;
    logic [3:0]    w_nibble;
    logic [7:0]    w_lit_mask;
    logic [7:0]    w_keep;
    logic [7:0]    w_en_next;

    // Hex nibble to active-low gfedcba segment pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Terminal count and frame-boundary detection.
    always_comb begin
        w_tc     = (r_presc == PRESC_TC);
        w_wrap   = w_tc && (r_idx == 3'd7);
        w_nibble = r_display[{r_idx, 2'b00} +: 4];
    end

    // Anode selection for the current digit, with optional leading-zero suppression.
    always_comb begin
        w_lit_mask = 8'h01 << r_idx;
        w_keep     = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 1; k < 8; k++) begin
            w_keep[k] = ((r_display >> (4 * k)) != 32'd0);
        end
`endif
        if (Blank) begin
            w_en_next = 8'hFF;
        end else begin
            w_en_next = ~(w_lit_mask & w_keep);
        end
    end

    // Prescaler and digit index; the index advances once per REFRESH_DIV cycles.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
            r_idx   <= r_idx;
        end
    end

    // Double buffer: Load fills the shadow, the frame boundary promotes it.
    // A Load landing exactly on the boundary bypasses the shadow.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_shadow  <= 32'd0;
            r_display <= 32'd0;
            r_pending <= 1'b0;
        end else begin
            if (Load) begin
                r_shadow <= DataIn;
            end else begin
                r_shadow <= r_shadow;
            end
            if (w_wrap) begin
                r_pending <= 1'b0;
                if (Load) begin
                    r_display <= DataIn;
                end else if (r_pending) begin
                    r_display <= r_shadow;
                end else begin
                    r_display <= r_display;
                end
            end else begin
                r_display <= r_display;
                r_pending <= r_pending | Load;
            end
        end
    end

    // Registered segment, anode and frame-tick outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out7      <= 7'h7F;
            en_out    <= 8'hFF;
            FrameTick <= 1'b0;
        end else begin
            out7      <= seg_decode(w_nibble);
            en_out    <= w_en_next;
            FrameTick <= w_wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV=4.
// A frame-level model (cycle number -> digit, frame boundary every 32 cycles)
// predicts the outputs each cycle; hand-computed literals pin the model.
module tb_seven_seg_scanner;

    localparam int DIV = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] DataIn;
    logic        Load;
    logic        Blank;
    logic [6:0]  out7;
    logic [7:0]  en_out;
    logic        FrameTick;

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;
    int ft_cnt   = 0;
    bit chk_on   = 1'b0;

    logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [7:0] EN_LIST [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    // model state
    int          m_n;
    logic [31:0] m_disp;
    logic [31:0] m_shadow;
    logic        m_pend;
    logic [6:0]  e_out7;
    logic [7:0]  e_en;
    logic        e_ft;

    seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .DataIn    (DataIn),
        .Load      (Load),
        .Blank     (Blank),
        .out7      (out7),
        .en_out    (en_out),
        .FrameTick (FrameTick)
    );

    always #5 Clk = ~Clk;

    function automatic int digit_of(input int n);
        return (n / DIV) % 8;
    endfunction

    function automatic bit is_wrap(input int n);
        return (n % (8 * DIV)) == (8 * DIV - 1);
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] v, input int d);
        return v[4*d +: 4];
    endfunction

    function automatic logic [7:0] model_en(input int d, input logic [31:0] v, input logic blank);
        logic [7:0] e;
        e = EN_LIST[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 32'd0) e = 8'hFF;
`endif
        if (blank) e = 8'hFF;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        k++;
        #1;
    endtask

    // Frame-level reference model: cycle number since reset selects the digit,
    // every 32nd cycle is the frame boundary where buffered data goes live.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_n      <= 0;
            m_disp   <= 32'd0;
            m_shadow <= 32'd0;
            m_pend   <= 1'b0;
            e_out7   <= 7'h7F;
            e_en     <= 8'hFF;
            e_ft     <= 1'b0;
        end else begin
            e_out7 <= SEG[nib(m_disp, digit_of(m_n))];
            e_en   <= model_en(digit_of(m_n), m_disp, Blank);
            e_ft   <= is_wrap(m_n);
            if (Load) m_shadow <= DataIn;
            if (is_wrap(m_n)) begin
                if (Load) m_disp <= DataIn;
                else if (m_pend) m_disp <= m_shadow;
                m_pend <= 1'b0;
            end else if (Load) begin
                m_pend <= 1'b1;
            end
            m_n <= m_n + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (chk_on) begin
            chk("model_out7", 32'(out7), 32'(e_out7));
            chk("model_en_out", 32'(en_out), 32'(e_en));
            chk("model_frametick", 32'(FrameTick), 32'(e_ft));
        end
    end

    initial begin
        Rst = 1'b1; Load = 1'b0; Blank = 1'b0; DataIn = 32'd0;
        // Scenario 1: reset values, then first digit after release
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_out7", 32'(out7), 32'h7F);
        chk("rst_en_out", 32'(en_out), 32'hFF);
        chk("rst_frametick", 32'(FrameTick), 32'h0);
        Rst = 1'b0; k = 0; chk_on = 1'b1;
        tick();
        chk("first_en_out", 32'(en_out), 32'hFE);
        chk("first_out7", 32'(out7), 32'h40);

        // Scenario 2: scan schedule and frame tick over two frames
        if (FrameTick) ft_cnt++;
        while (k < 64) begin
            tick();
`ifdef LEADING_ZERO_BLANK_EN
            chk("scan_en", 32'(en_out), (digit_of(k - 1) == 0) ? 32'hFE : 32'hFF);
`else
            chk("scan_en", 32'(en_out), 32'(EN_LIST[digit_of(k - 1)]));
`endif
            if (FrameTick) ft_cnt++;
            if (k == 32) chk("ft_at_wrap", 32'(FrameTick), 32'h1);
        end
        chk("ft_count", ft_cnt, 2);

        // Scenario 3: mid-frame load held until the boundary
        while (k < 78) tick();
        DataIn = 32'h12345678; Load = 1'b1;
        tick();
        Load = 1'b0;
        while (k < 85) tick();
        chk("s3_old_digit", 32'(out7), 32'h40);
        while (k < 97) tick();
        chk("s3_digit0", 32'(out7), 32'b0000000);
        while (k < 125) tick();
        chk("s3_digit7", 32'(out7), 32'b1111001);

        // Scenario 4: two loads in one frame, last one wins
        while (k < 134) tick();
        DataIn = 32'hAAAAAAAA; Load = 1'b1;
        tick();
        Load = 1'b0;
        while (k < 139) tick();
        DataIn = 32'h0000000F; Load = 1'b1;
        tick();
        Load = 1'b0;
        while (k < 161) tick();
        chk("s4_digit0", 32'(out7), 32'b0001110);
        while (k < 165) tick();
        chk("s4_digit1", 32'(out7), 32'b1000000);
`ifdef LEADING_ZERO_BLANK_EN
        chk("s4_digit1_en", 32'(en_out), 32'hFF);
`else
        chk("s4_digit1_en", 32'(en_out), 32'hFD);
`endif

        // Scenario 5: load exactly on the boundary bypasses the shadow
        while (k < 191) tick();
        DataIn = 32'hDEADBEEF; Load = 1'b1;
        tick();
        Load = 1'b0;
        chk("s5_frametick", 32'(FrameTick), 32'h1);
        tick();
        chk("s5_digit0", 32'(out7), 32'b0001110);
        while (k < 221) tick();
        chk("s5_digit7", 32'(out7), 32'b0100001);
        while (k < 225) tick();
        chk("s5_next_frame_digit0", 32'(out7), 32'b0001110);

        // Scenario 6: blanking, then mid-frame reset
        while (k < 229) tick();
        Blank = 1'b1;
        repeat (10) begin
            tick();
            chk("s6_blank_en", 32'(en_out), 32'hFF);
        end
        Blank = 1'b0;
        repeat (12) tick();
        Rst = 1'b1;
        #1;
        chk("s6_rst_out7", 32'(out7), 32'h7F);
        chk("s6_rst_en_out", 32'(en_out), 32'hFF);
        chk("s6_rst_frametick", 32'(FrameTick), 32'h0);
        tick();
        Rst = 1'b0; k = 0;
        tick();
        chk("s6_after_rst_en", 32'(en_out), 32'hFE);
        chk("s6_after_rst_out7", 32'(out7), 32'h40);
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
